// File: rtl/ram_fifo_mc.sv
// Multi-channel FIFO: CH_NUM logical queues in one shared simple-dual-port RAM, round-robin reads.
// Optional per-channel flush input is compiled in when RAM_FIFO_MC_FLUSH_EN is defined.

module ram_fifo_mc #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned CH_WIDTH   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AFULL_TH   = DEPTH - 4,
  parameter int unsigned AEMPTY_TH  = 4,
  parameter int unsigned SIZE_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [CH_WIDTH-1:0]          wr_ch,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic [CH_NUM-1:0]            wr_ready,
  output logic                         rd_valid,
  output logic [CH_WIDTH-1:0]          rd_ch,
  output logic [DATA_WIDTH-1:0]        rd_data,
  input  logic                         rd_ready,
  output logic [CH_NUM*SIZE_WIDTH-1:0] count,
  output logic [CH_NUM-1:0]            afull,
  output logic [CH_NUM-1:0]            aempty
`ifdef RAM_FIFO_MC_FLUSH_EN
  ,
  input  logic [CH_NUM-1:0]            flush
`endif
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned ADDR_W    = CH_WIDTH + PTR_W;
  localparam int unsigned RAM_WORDS = 1 << ADDR_W;

  typedef struct packed {
    logic [CH_WIDTH-1:0]   ch;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  logic [DATA_WIDTH-1:0] mem [RAM_WORDS];
  logic [SIZE_WIDTH-1:0] cnt_q    [CH_NUM];
  logic [SIZE_WIDTH-1:0] cnt_d    [CH_NUM];
  logic [PTR_W-1:0]      wr_ptr_q [CH_NUM];
  logic [PTR_W-1:0]      rd_ptr_q [CH_NUM];

  logic [CH_NUM-1:0]     flush_mask;
  logic [CH_NUM-1:0]     wr_inc;
  logic [CH_NUM-1:0]     rd_dec;
  logic [CH_NUM-1:0]     req;
  logic                  wr_acc;
  logic [PTR_W-1:0]      wr_ptr_sel;
  logic [PTR_W-1:0]      rd_ptr_sel;
  logic [CH_WIDTH-1:0]   last_q;
  logic [CH_WIDTH-1:0]   gnt;
  logic                  found;
  logic                  credit;
  logic                  issue;
  logic [1:0]            occ;
  logic                  pop;
  logic                  push;

  logic                  s1_vld_q;
  word_t                 s1_q;
  logic [1:0]            ob_vld_q;
  logic [1:0]            ob_vld_d;
  word_t                 ob_q [2];
  word_t                 ob_d [2];

`ifdef RAM_FIFO_MC_FLUSH_EN
  assign flush_mask = flush;
`else
  assign flush_mask = '0;
`endif

  function automatic logic ch_hit(input logic [CH_NUM-1:0] mask, input logic [CH_WIDTH-1:0] ch);
    ch_hit = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (mask[c] && (ch == CH_WIDTH'(c))) ch_hit = 1'b1;
    end
  endfunction

  // Write accept: a flushed channel drops its same-cycle write
  always_comb begin
    wr_inc     = '0;
    wr_ptr_sel = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (wr_ch == CH_WIDTH'(c)) begin
        wr_ptr_sel = wr_ptr_q[c];
        wr_inc[c]  = wr_valid && wr_ready[c] && !flush_mask[c];
      end
    end
    wr_acc = |wr_inc;
  end

  assign pop = ob_vld_q[0] && rd_ready;

  // Round-robin issue: channels after last_q first, then wrap; gated by output-buffer credit
  always_comb begin
    req        = '0;
    rd_dec     = '0;
    rd_ptr_sel = '0;
    found      = 1'b0;
    gnt        = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      req[c] = (cnt_q[c] != '0) && !flush_mask[c];
    end
    for (int c = 0; c < CH_NUM; c++) begin
      if (!found && req[c] && (CH_WIDTH'(c) > last_q)) begin
        found = 1'b1;
        gnt   = CH_WIDTH'(c);
      end
    end
    for (int c = 0; c < CH_NUM; c++) begin
      if (!found && req[c] && (CH_WIDTH'(c) <= last_q)) begin
        found = 1'b1;
        gnt   = CH_WIDTH'(c);
      end
    end
    occ    = 2'(ob_vld_q[0]) + 2'(ob_vld_q[1]) + 2'(s1_vld_q);
    credit = (occ - 2'(pop)) < 2'd2;
    issue  = found && credit;
    for (int c = 0; c < CH_NUM; c++) begin
      if (gnt == CH_WIDTH'(c)) begin
        rd_ptr_sel = rd_ptr_q[c];
        rd_dec[c]  = issue;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      cnt_d[c] = cnt_q[c];
      case ({wr_inc[c], rd_dec[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + SIZE_WIDTH'(1);
        2'b01:   cnt_d[c] = cnt_q[c] - SIZE_WIDTH'(1);
        default: cnt_d[c] = cnt_q[c];
      endcase
      if (flush_mask[c]) cnt_d[c] = '0;
    end
  end

  // Output buffer: pop head, drop flushed entries, then append the RAM stage word
  always_comb begin
    ob_vld_d = ob_vld_q;
    ob_d[0]  = ob_q[0];
    ob_d[1]  = ob_q[1];
    if (pop) begin
      ob_vld_d = {1'b0, ob_vld_q[1]};
      ob_d[0]  = ob_q[1];
    end
    if (ob_vld_d[1] && ch_hit(flush_mask, ob_d[1].ch)) ob_vld_d[1] = 1'b0;
    if (ob_vld_d[0] && ch_hit(flush_mask, ob_d[0].ch)) begin
      ob_vld_d = {1'b0, ob_vld_d[1]};
      ob_d[0]  = ob_d[1];
    end
    push = s1_vld_q && !ch_hit(flush_mask, s1_q.ch);
    if (push) begin
      if (!ob_vld_d[0]) begin
        ob_vld_d[0] = 1'b1;
        ob_d[0]     = s1_q;
      end else begin
        ob_vld_d[1] = 1'b1;
        ob_d[1]     = s1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        cnt_q[c]    <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      wr_ready <= '0;
      afull    <= '0;
      aempty   <= '0;
      last_q   <= '0;
      s1_vld_q <= 1'b0;
      ob_vld_q <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        cnt_q[c] <= cnt_d[c];
        if (wr_inc[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
        if (flush_mask[c])  rd_ptr_q[c] <= wr_ptr_q[c];
        else if (rd_dec[c]) rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
        wr_ready[c] <= cnt_d[c] < SIZE_WIDTH'(DEPTH);
        afull[c]    <= cnt_q[c] > SIZE_WIDTH'(AFULL_TH);
        aempty[c]   <= cnt_q[c] < SIZE_WIDTH'(AEMPTY_TH);
      end
      if (issue) last_q <= gnt;
      s1_vld_q <= issue;
      ob_vld_q <= ob_vld_d;
    end
  end

  // Datapath storage carries no reset; validity comes from the control registers above
  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wr_ch, wr_ptr_sel}] <= wr_data;
    if (issue) begin
      s1_q.ch   <= gnt;
      s1_q.data <= mem[{gnt, rd_ptr_sel}];
    end
    ob_q[0] <= ob_d[0];
    ob_q[1] <= ob_d[1];
  end

  assign rd_valid = ob_vld_q[0];
  assign rd_ch    = ob_q[0].ch;
  assign rd_data  = ob_q[0].data;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_count
    assign count[g*SIZE_WIDTH +: SIZE_WIDTH] = cnt_q[g];
  end

endmodule

// File: doc/ram_fifo_mc.md
Name: ram_fifo_mc

Overview:
- Multi-channel successor to the single-channel RAM FIFO: CH_NUM independent logical FIFOs share one simple-dual-port RAM, each in a fixed DEPTH-entry region.
- Single channel-tagged write port; single channel-tagged read port with round-robin arbitration across non-empty channels.
- Sits between the chain-control ingress demux and the per-function egress scheduler.
- Per-channel fill levels and almost-full/almost-empty flags feed flow control.

Parameters:
- CH_NUM, 4, number of logical channels (2..16).
- CH_WIDTH, $clog2(CH_NUM), channel index width (minimum 1).
- DATA_WIDTH, 32, payload width.
- DEPTH, 16, entries per channel; power of two, >=4.
- AFULL_TH, DEPTH-4, afull[c] set when count[c] > AFULL_TH.
- AEMPTY_TH, 4, aempty[c] set when count[c] < AEMPTY_TH.
- SIZE_WIDTH, $clog2(DEPTH+1), per-channel count width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  write request.
- wr_ch  in  CH_WIDTH  target channel of write.
- wr_data  in  DATA_WIDTH  write payload.
- wr_ready  out  CH_NUM  per-channel space available (registered).
- rd_valid  out  1  output word valid.
- rd_ch  out  CH_WIDTH  channel of output word.
- rd_data  out  DATA_WIDTH  output payload.
- rd_ready  in  1  downstream accept.
- count  out  CH_NUM*SIZE_WIDTH  per-channel occupancy, channel c at [c*SIZE_WIDTH +: SIZE_WIDTH].
- afull  out  CH_NUM  per-channel almost full.
- aempty  out  CH_NUM  per-channel almost empty.

Behaviour:
- Reset: one clock; reset is synchronous and active-high, port rst sampled on posedge clk.
  - All pointers and counts clear to 0; wr_ready = 0; rd_valid = 0; afull = 0; aempty = 0.
  - wr_ready goes all-ones the cycle after rst deasserts.
  - rd_data and rd_ch are don't-care while rd_valid = 0.
- Reset mid-operation: all stored and in-flight words are discarded; no rd_valid in the cycle after rst.
- Write accept and RAM write:
  - A write is accepted when wr_valid && wr_ready[wr_ch].
  - A write to a channel whose ready bit is 0 is ignored; it is not an error.
  - The RAM write address is {wr_ch, wr_ptr[wr_ch]}. Each pointer wraps DEPTH-1 -> 0.
- Per-channel count:
  - Increments on write accept to that channel.
  - Decrements on read issue (RAM read launched) from that channel.
  - Simultaneous increment and decrement leaves it unchanged.
  - Range is 0..DEPTH.
- wr_ready[c] (registered) = 1 iff the next count < DEPTH.
  - A write that fills the channel (count 15 -> 16 with DEPTH=16) drops wr_ready[c] the following cycle.
  - A read issue from a full channel raises wr_ready[c] the following cycle.
- Read path is a 3-stage pipeline:
  - Arbiter/issue: round-robin grant among channels with count > 0. The search starts at last_grant+1 mod CH_NUM. Issue only when the output buffer has a free credit.
  - RAM read: 1-cycle registered.
  - Output buffer: 2-entry skid buffer presenting rd_valid, rd_ch, rd_data.
  - Credit accounting covers words in flight; the buffer never overflows.
  - Sustained throughput is 1 word/clk with rd_ready held high.
- Latency:
  - Write accepted at cycle T into an empty block -> rd_valid at T+3.
  - Write-to-count visibility is T+1.
- Ordering:
  - Per-channel order is strict FIFO.
  - With channels A and B continuously non-empty and rd_ready=1, output alternates A,B,A,B.
- Output stability: rd_valid, rd_ch and rd_data hold stable while rd_valid && !rd_ready.
- Flags: afull and aempty are registered from count (1-cycle lag).
- Hazards:
  - A read never targets a slot written in the same cycle, because the count update gates issue.
  - No RAM read-during-write behaviour is required.

Optional Feature:
- Macro: RAM_FIFO_MC_FLUSH_EN.
- Enabled: adds input flush, width CH_NUM.
  - flush[c] high for one cycle: count[c] := 0, rd_ptr[c] := wr_ptr[c].
  - A write to c in the same cycle is dropped.
  - Words from c already in the pipeline or output buffer are discarded before presentation; rd_valid is never raised for them.
  - wr_ready[c] = 1 the next cycle.
  - Other channels are unaffected.
- Disabled: the port is absent and no flush logic is synthesised.

Test Plan:
1. Reset, then 1 write ch2 data 0xA5 at T -> count[2]=1 at T+1; rd_valid=1, rd_ch=2, rd_data=0xA5 at T+3; count[2]=0 after issue.
2. DEPTH=16, fill ch0 with 16 words, rd_ready=0 -> wr_ready[0]=0 the cycle after the 16th; 17th write ignored; afull[0]=1; drain all -> data 0..15 in order.
3. Fill ch1 and ch3 with 8 words each, rd_ready=1 -> rd_ch sequence 1,3,1,3,...; 16 words in 16 consecutive cycles after first valid.
4. Random rd_ready toggling (50%), 1000 random writes over 4 channels -> per-channel scoreboard exact; rd_* stable under backpressure; no loss or duplication.
5. Assert rst for 1 cycle with 5 words stored and 2 in flight -> rd_valid=0 the next cycle; all counts 0; wr_ready=4'hF the cycle after.
6. (FLUSH_EN) ch0 holds 6 words with 2 in output buffer, ch1 holds 3; pulse flush[0] -> only ch1's 3 words emerge; count[0]=0.
